mix_columns_seq: RTL and testbench

Sequential, parametrised AES MixColumns / InvMixColumns engine operating on a full 128-bit state. It accepts a state over a valid/ready handshake and transforms COLS_PER_CYCLE 32-bit columns per clock, in place. It then presents the result until the consumer takes it. It sits in the round datapath between ShiftRows and AddRoundKey and serves both the encrypt and decrypt paths.

---
 rtl/mix_columns_seq.sv | 174 +++++++++++++++++
 tb/tb_mix_columns_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mix_columns_seq.sv
// mix_columns_seq: sequential AES MixColumns / InvMixColumns engine.
// A 128-bit state is accepted over a valid/ready handshake and transformed
// in place, COLS_PER_CYCLE columns per clock. The result is then held until
// the consumer takes it.
// Optional feature macro: MIXCOL_INV_EN adds the InvMixColumns datapath and
// the mode flop. Without it in_inv is ignored and only the forward transform
// is built.
module mix_columns_seq #(
  parameter int BYTE           = 8,
  parameter int DWORD          = 32,
  parameter int LENGTH         = 128,
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_inv,
  input  logic [LENGTH-1:0] in_state,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LENGTH-1:0] out_state,
  output logic              busy
);

  // Reject unsupported geometries while the design is being elaborated.
  if (BYTE != 8 || DWORD != 32 || LENGTH != 128 ||
      !(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : gBadConfig
    $error("mix_columns_seq: unsupported parameters (COLS_PER_CYCLE must be 1, 2 or 4)");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

  stateT             state_q, state_d;
  logic [LENGTH-1:0] work_q, work_d;
  logic [1:0]        colCnt_q, colCnt_d;
  logic [2:0]        colIdx;
  logic              lastGroup;

  // Multiply by x in GF(2^8) modulo 0x11B.
  function automatic logic [BYTE-1:0] xtime(input logic [BYTE-1:0] x);
    xtime = {x[BYTE-2:0], 1'b0} ^ (x[BYTE-1] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [BYTE-1:0] mul3(input logic [BYTE-1:0] x);
    mul3 = xtime(x) ^ x;
  endfunction

  // Forward MixColumns on one column; byte 0 is the column's MSB.
  function automatic logic [DWORD-1:0] fwdCol(input logic [DWORD-1:0] col);
    logic [BYTE-1:0] b0, b1, b2, b3;
    b0 = col[31:24];
    b1 = col[23:16];
    b2 = col[15:8];
    b3 = col[7:0];
    fwdCol = {xtime(b0) ^ mul3(b1) ^ b2 ^ b3,
              b0 ^ xtime(b1) ^ mul3(b2) ^ b3,
              b0 ^ b1 ^ xtime(b2) ^ mul3(b3),
              mul3(b0) ^ b1 ^ b2 ^ xtime(b3)};
  endfunction

`ifdef MIXCOL_INV_EN
  logic modeInv_q, modeInv_d;

  function automatic logic [BYTE-1:0] mul9(input logic [BYTE-1:0] x);
    mul9 = xtime(xtime(xtime(x))) ^ x;
  endfunction

  function automatic logic [BYTE-1:0] mulB(input logic [BYTE-1:0] x);
    mulB = xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
  endfunction

  function automatic logic [BYTE-1:0] mulD(input logic [BYTE-1:0] x);
    mulD = xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
  endfunction

  function automatic logic [BYTE-1:0] mulE(input logic [BYTE-1:0] x);
    mulE = xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
  endfunction

  // InvMixColumns on one column, coefficient row {0e,0b,0d,09} rotated.
  function automatic logic [DWORD-1:0] invCol(input logic [DWORD-1:0] col);
    logic [BYTE-1:0] b0, b1, b2, b3;
    b0 = col[31:24];
    b1 = col[23:16];
    b2 = col[15:8];
    b3 = col[7:0];
    invCol = {mulE(b0) ^ mulB(b1) ^ mulD(b2) ^ mul9(b3),
              mul9(b0) ^ mulE(b1) ^ mulB(b2) ^ mulD(b3),
              mulD(b0) ^ mul9(b1) ^ mulE(b2) ^ mulB(b3),
              mulB(b0) ^ mulD(b1) ^ mul9(b2) ^ mulE(b3)};
  endfunction
`else
  logic unusedInInv;
  assign unusedInInv = in_inv;
`endif

  // State, working register, column counter and mode, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      work_q    <= '0;
      colCnt_q  <= '0;
`ifdef MIXCOL_INV_EN
      modeInv_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      colCnt_q  <= colCnt_d;
`ifdef MIXCOL_INV_EN
      modeInv_q <= modeInv_d;
`endif
    end
  end

  // The group just processed is the last one when it reaches column 3.
  assign lastGroup = (({1'b0, colCnt_q} + 3'(COLS_PER_CYCLE)) == 3'd4);

  // Next-state logic: accept in IDLE, transform one column group per BUSY
  // cycle, hold the result in DONE until it is popped.
  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    colCnt_d  = colCnt_q;
    colIdx    = '0;
`ifdef MIXCOL_INV_EN
    modeInv_d = modeInv_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          work_d    = in_state;
          colCnt_d  = '0;
`ifdef MIXCOL_INV_EN
          modeInv_d = in_inv;
`endif
          state_d   = BUSY;
        end
      end
      BUSY: begin
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
          colIdx = {1'b0, colCnt_q} + 3'(g);
`ifdef MIXCOL_INV_EN
          work_d[LENGTH-1-DWORD*colIdx -: DWORD] = modeInv_q
              ? invCol(work_q[LENGTH-1-DWORD*colIdx -: DWORD])
              : fwdCol(work_q[LENGTH-1-DWORD*colIdx -: DWORD]);
`else
          work_d[LENGTH-1-DWORD*colIdx -: DWORD] =
              fwdCol(work_q[LENGTH-1-DWORD*colIdx -: DWORD]);
`endif
        end
        colCnt_d = colCnt_q + 2'(COLS_PER_CYCLE);
        if (lastGroup) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state; in_ready is also
  // held low while reset is asserted.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == BUSY);
  assign out_state = work_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// tb_mix_columns_seq: directed bench for mix_columns_seq with one
// instance at COLS_PER_CYCLE=1 and one at COLS_PER_CYCLE=4.
module tb_mix_columns_seq;

  localparam logic [127:0] V_IN   = 128'hdb135345_f20a225c_01010101_2d26314c;
  localparam logic [127:0] V_OUT  = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
  localparam logic [127:0] V4_IN  = 128'hc6c6c6c6_d4d4d4d5_01010101_f20a225c;
  localparam logic [127:0] V4_OUT = 128'hc6c6c6c6_d5d5d7d6_01010101_9fdc589d;
  localparam logic [127:0] OTHER  = 128'h00112233_44556677_8899aabb_ccddeeff;

  logic         clk;
  logic         rst;
  logic         inInv;
  logic [127:0] inState;
  logic         outReady;

  logic         inValid1, inReady1, outValid1, busy1;
  logic [127:0] outState1;
  logic         inValid4, inReady4, outValid4, busy4;
  logic [127:0] outState4;

  int testsRun;
  int failCount;

  logic [127:0] result;
  int           lat;
  logic         busySeen;

  mix_columns_seq #(.COLS_PER_CYCLE(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inValid1),
    .in_ready  (inReady1),
    .in_inv    (inInv),
    .in_state  (inState),
    .out_valid (outValid1),
    .out_ready (outReady),
    .out_state (outState1),
    .busy      (busy1)
  );

  mix_columns_seq #(.COLS_PER_CYCLE(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inValid4),
    .in_ready  (inReady4),
    .in_inv    (inInv),
    .in_state  (inState),
    .out_valid (outValid4),
    .out_ready (outReady),
    .out_state (outState4),
    .busy      (busy4)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: count it, and report a failure with observed/expected.
  task automatic checkOutput(input string tag, input logic [127:0] obs,
                             input logic [127:0] exp);
    testsRun++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Push one state into the chosen instance, wait (bounded) for out_valid
  // and report the result, the latency in edges after acceptance and
  // whether busy was high in the first cycle. Optionally pop the result.
  task automatic applyStimulus(input bit sel4, input logic [127:0] st,
                               input logic inv, input bit doPop,
                               output logic [127:0] res, output int latency,
                               output logic busyFirst);
    @(negedge clk);
    inState = st;
    inInv   = inv;
    if (sel4) inValid4 = 1'b1;
    else      inValid1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inValid1  = 1'b0;
    inValid4  = 1'b0;
    busyFirst = sel4 ? busy4 : busy1;
    latency   = 0;
    while (!(sel4 ? outValid4 : outValid1) && latency < 20) begin
      @(negedge clk);
      latency++;
    end
    res = sel4 ? outState4 : outState1;
    if (doPop) begin
      outReady = 1'b1;
      @(negedge clk);
      outReady = 1'b0;
    end
  endtask

  initial begin
    testsRun  = 0;
    failCount = 0;
    rst       = 1'b1;
    inInv     = 1'b0;
    inState   = '0;
    outReady  = 1'b0;
    inValid1  = 1'b0;
    inValid4  = 1'b0;

    // Reset state.
    #2;
    checkOutput("reset_in_ready", {127'b0, inReady1}, 128'd0);
    checkOutput("reset_out_valid", {127'b0, outValid1}, 128'd0);
    checkOutput("reset_busy", {127'b0, busy1}, 128'd0);
    checkOutput("reset_out_state", outState1, 128'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("release_in_ready", {127'b0, inReady1}, 128'd1);

    // Forward transform, one column per cycle.
    applyStimulus(1'b0, V_IN, 1'b0, 1'b1, result, lat, busySeen);
    checkOutput("fwd_result", result, V_OUT);
    checkOutput("fwd_latency", 128'(lat), 128'd4);
    checkOutput("fwd_busy", {127'b0, busySeen}, 128'd1);

`ifdef MIXCOL_INV_EN
    // Inverse transform recovers the original state.
    applyStimulus(1'b0, V_OUT, 1'b1, 1'b1, result, lat, busySeen);
    checkOutput("inv_result", result, V_IN);
    checkOutput("inv_latency", 128'(lat), 128'd4);
`else
    // Without the inverse datapath in_inv=1 still yields the forward result.
    applyStimulus(1'b0, V_IN, 1'b1, 1'b1, result, lat, busySeen);
    checkOutput("noinv_result", result, V_OUT);
    checkOutput("noinv_latency", 128'(lat), 128'd4);
`endif

    // Four columns per cycle.
    applyStimulus(1'b1, V4_IN, 1'b0, 1'b1, result, lat, busySeen);
    checkOutput("cpc4_result", result, V4_OUT);
    checkOutput("cpc4_latency", 128'(lat), 128'd1);
    checkOutput("cpc4_in_ready", {127'b0, inReady4}, 128'd1);

    // Backpressure: result held, new input ignored, then popped.
    applyStimulus(1'b0, V_IN, 1'b0, 1'b0, result, lat, busySeen);
    checkOutput("bp_result", result, V_OUT);
    inValid1 = 1'b1;
    inState  = OTHER;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("bp_hold_state", outState1, V_OUT);
      checkOutput("bp_hold_in_ready", {127'b0, inReady1}, 128'd0);
      checkOutput("bp_hold_out_valid", {127'b0, outValid1}, 128'd1);
    end
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
    checkOutput("bp_pop_out_valid", {127'b0, outValid1}, 128'd0);
    checkOutput("bp_pop_in_ready", {127'b0, inReady1}, 128'd1);
    inValid1 = 1'b0;

    // Asynchronous reset in the second BUSY cycle.
    @(negedge clk);
    inState  = V_IN;
    inInv    = 1'b0;
    inValid1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inValid1 = 1'b0;
    @(negedge clk);
    checkOutput("midrst_busy_before", {127'b0, busy1}, 128'd1);
    #1 rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", {127'b0, outValid1}, 128'd0);
    checkOutput("midrst_busy", {127'b0, busy1}, 128'd0);
    checkOutput("midrst_out_state", outState1, 128'd0);
    checkOutput("midrst_in_ready", {127'b0, inReady1}, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midrst_release_in_ready", {127'b0, inReady1}, 128'd1);
    applyStimulus(1'b0, V_IN, 1'b0, 1'b1, result, lat, busySeen);
    checkOutput("midrst_fresh_result", result, V_OUT);
    checkOutput("midrst_fresh_latency", 128'(lat), 128'd4);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
